tile_matmul_engine: RTL

Parametrised integer matrix-multiply engine that computes C = A × B for matrices held in a shared dual-port synchronous RAM. It reads dimensions from a header word, walks C in 2×2 output tiles, and fetches 2×2 operand tiles over both RAM ports (A on port a, B on port b). It accumulates each tile internally and writes the result back through both ports. Odd dimensions are zero-padded, and the block runs under a start/busy/done handshake, so one instance can be reused without reset.

---
 rtl/tile_matmul_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tile_matmul_engine.sv
// Tiled integer matrix multiply C = A x B over a shared dual-port RAM.
// Walks C in 2x2 tiles; A streams on port a, B on port b, C writes on both.
module tile_matmul_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DIM_WIDTH  = 8,
   parameter int HDR_ADDR   = 0,
   parameter int A_BASE     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] rdata_a,
   input  logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  we_a,
   output logic                  we_b,
   output logic [DATA_WIDTH-1:0] wdata_a,
   output logic [DATA_WIDTH-1:0] wdata_b
);

   localparam int EW = 3 * DIM_WIDTH + 2;
   localparam int PW = (EW > ADDR_WIDTH) ? EW : ADDR_WIDTH + 1;
   localparam int CW = DIM_WIDTH + 1;

   typedef logic [PW-1:0] wide_t;
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t  ONE   = cnt_t'(1);
   localparam cnt_t  TWO   = cnt_t'(2);
   localparam wide_t LIMIT = wide_t'(1) << ADDR_WIDTH;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_HDR_WAIT,
      S_TILE_INIT,
      S_FETCH,
      S_MAC,
      S_WRITE0,
      S_WRITE1,
      S_DONE
   } state_t;

   state_t state, state_n;

   cnt_t dm, dk, dn;
   cnt_t ti, tj, tk;
   logic [2:0] f;
   logic [ADDR_WIDTH-1:0] b_base, c_base;
   logic [DATA_WIDTH-1:0] a_t [4];
   logic [DATA_WIDTH-1:0] b_t [4];
   logic [DATA_WIDTH-1:0] acc [4];

   // Header decode; sums kept wide so the range test never truncates
   logic [DIM_WIDTH-1:0] h_m, h_k, h_n;
   wide_t h_b, h_c, h_end;
   logic  h_zero, h_ovf;

   assign h_m = rdata_a[DIM_WIDTH-1:0];
   assign h_k = rdata_a[2*DIM_WIDTH-1:DIM_WIDTH];
   assign h_n = rdata_a[3*DIM_WIDTH-1:2*DIM_WIDTH];

   always_comb begin
      h_b    = wide_t'(A_BASE) + wide_t'(h_m) * wide_t'(h_k);
      h_c    = h_b + wide_t'(h_k) * wide_t'(h_n);
      h_end  = h_c + wide_t'(h_m) * wide_t'(h_n);
      h_zero = (h_m == '0) || (h_k == '0) || (h_n == '0);
      h_ovf  = h_end > LIMIT;
   end

   // Operand fetch addressing and capture range checks
   cnt_t ar, ac, br, bc;
   wide_t fa, fb;
   logic [2:0] fm;
   logic a_ok, b_ok;

   always_comb begin
      ar   = ti + cnt_t'(f[1]);
      ac   = tk + cnt_t'(f[0]);
      br   = tk + cnt_t'(f[1]);
      bc   = tj + cnt_t'(f[0]);
      fa   = wide_t'(A_BASE) + wide_t'(ar) * wide_t'(dk)
           + wide_t'(ac);
      fb   = wide_t'(b_base) + wide_t'(br) * wide_t'(dn)
           + wide_t'(bc);
      fm   = f - 3'd1;
      a_ok = (ti + cnt_t'(fm[1]) < dm)
          && (tk + cnt_t'(fm[0]) < dk);
      b_ok = (tk + cnt_t'(fm[1]) < dk)
          && (tj + cnt_t'(fm[0]) < dn);
   end

   // Result write-back addressing
   logic  wsel;
   cnt_t  wr, wc1;
   wide_t ca;

   always_comb begin
      wsel = (state == S_WRITE1);
      wr   = ti + cnt_t'(wsel);
      wc1  = tj + ONE;
      ca   = wide_t'(c_base) + wide_t'(wr) * wide_t'(dn)
           + wide_t'(tj);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = (state != S_IDLE);
      done    = 1'b0;
      addr_a  = '0;
      addr_b  = '0;
      we_a    = 1'b0;
      we_b    = 1'b0;
      wdata_a = '0;
      wdata_b = '0;
      unique case (state)
         S_IDLE: begin
            if (start) state_n = S_HDR;
         end
         S_HDR: begin
            addr_a  = ADDR_WIDTH'(HDR_ADDR);
            state_n = S_HDR_WAIT;
         end
         S_HDR_WAIT: begin
            if (h_zero || h_ovf) state_n = S_DONE;
            else                 state_n = S_TILE_INIT;
         end
         S_TILE_INIT: begin
            state_n = S_FETCH;
         end
         S_FETCH: begin
            addr_a = fa[ADDR_WIDTH-1:0];
            addr_b = fb[ADDR_WIDTH-1:0];
            if (f == 3'd4) state_n = S_MAC;
         end
         S_MAC: begin
            if (tk + TWO < dk) state_n = S_FETCH;
            else               state_n = S_WRITE0;
         end
         S_WRITE0, S_WRITE1: begin
            addr_a  = ca[ADDR_WIDTH-1:0];
            addr_b  = ca[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            wdata_a = acc[{wsel, 1'b0}];
            wdata_b = acc[{wsel, 1'b1}];
            we_a    = (wr < dm) && (tj < dn);
            we_b    = (wr < dm) && (wc1 < dn);
            if (state == S_WRITE0)
               state_n = S_WRITE1;
            else if ((tj + TWO < dn) || (ti + TWO < dm))
               state_n = S_TILE_INIT;
            else
               state_n = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err    <= 1'b0;
         dm     <= '0;
         dk     <= '0;
         dn     <= '0;
         ti     <= '0;
         tj     <= '0;
         tk     <= '0;
         f      <= '0;
         b_base <= '0;
         c_base <= '0;
         for (int e = 0; e < 4; e++) begin
            a_t[e] <= '0;
            b_t[e] <= '0;
            acc[e] <= '0;
         end
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) err <= 1'b0;
            end
            S_HDR_WAIT: begin
               dm     <= cnt_t'(h_m);
               dk     <= cnt_t'(h_k);
               dn     <= cnt_t'(h_n);
               b_base <= h_b[ADDR_WIDTH-1:0];
               c_base <= h_c[ADDR_WIDTH-1:0];
               ti     <= '0;
               tj     <= '0;
               err    <= h_ovf && !h_zero;
            end
            S_TILE_INIT: begin
               tk <= '0;
               f  <= '0;
               for (int e = 0; e < 4; e++) acc[e] <= '0;
            end
            S_FETCH: begin
               f <= f + 3'd1;
               // element f-1 arrives this cycle from last cycle's address
               if (f != 3'd0) begin
                  a_t[fm[1:0]] <= a_ok ? rdata_a : '0;
                  b_t[fm[1:0]] <= b_ok ? rdata_b : '0;
               end
            end
            S_MAC: begin
               tk <= tk + TWO;
               f  <= '0;
               for (int p = 0; p < 2; p++) begin
                  for (int q = 0; q < 2; q++) begin
                     acc[p*2+q] <= acc[p*2+q]
                                 + a_t[p*2]   * b_t[q]
                                 + a_t[p*2+1] * b_t[2+q];
                  end
               end
            end
            S_WRITE1: begin
               if (tj + TWO < dn) begin
                  tj <= tj + TWO;
               end else begin
                  tj <= '0;
                  ti <= ti + TWO;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
